// File: rtl/sprite_draw_scheduler.sv
// Purpose : round-robin share of the VGA framebuffer write port among NUM_REQ sprite draw engines.
// Latency : 1 cycle from engine coordinate to vga_x/vga_y/vga_plot; 3 non-drawing cycles between draws.
// Backpr. : none toward the VGA side; requests are held off simply by staying low until the FSM returns to IDLE.
//
// Optional feature macro: SPRITE_TRANSPARENCY_EN (suppresses vga_plot for TRANS_COLOUR pixels).
//
// Ports:
//   clock_all, reset_all          clock / asynchronous active-high reset
//   req[NUM_REQ]                  level draw requests, sampled only in IDLE
//   eng_done/eng_x/eng_y/eng_colour  per-engine done flag, coordinates, colour ROM q
//   eng_enable, eng_reset_n       one-hot engine enable, active-low engine counter reset
//   vga_x/vga_y/vga_colour/vga_plot  aligned pixel stream to the VGA adapter
//   busy, ack, timeout            status: not idle, draw-finished pulse, watchdog abort pulse
module sprite_draw_scheduler #(
    parameter int          NUM_REQ      = 4,
    parameter int          MAX_CYCLES   = 8192,
    parameter logic [2:0]  TRANS_COLOUR = 3'b000
) (
    input  logic                   clock_all,
    input  logic                   reset_all,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     eng_done,
    input  logic [9*NUM_REQ-1:0]   eng_x,
    input  logic [8*NUM_REQ-1:0]   eng_y,
    input  logic [3*NUM_REQ-1:0]   eng_colour,
    output logic [NUM_REQ-1:0]     eng_enable,
    output logic [NUM_REQ-1:0]     eng_reset_n,
    output logic [8:0]             vga_x,
    output logic [7:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   timeout
);

    localparam int             IW     = $clog2(NUM_REQ);
    localparam int             CW     = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0]  MAX_M1 = CW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FINISH} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       winner, last_grant, arb_idx;
    logic                arb_found;
    logic [CW-1:0]       count;
    logic                abort;
    logic                stage_vld;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                win_done;

    logic [8:0] x_arr   [NUM_REQ];
    logic [7:0] y_arr   [NUM_REQ];
    logic [2:0] col_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign x_arr[g]   = eng_x[9*g +: 9];
        assign y_arr[g]   = eng_y[8*g +: 8];
        assign col_arr[g] = eng_colour[3*g +: 3];
    end

    assign win_onehot = NUM_REQ'(1) << winner;
    assign win_done   = eng_done[winner];

    // Round-robin: scan last_grant+1, +2, ... so the previous winner has lowest priority.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last_grant) + i) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clock_all or posedge reset_all) begin
        if (reset_all) begin
            state      <= IDLE;
            winner     <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            count      <= '0;
            abort      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:   if (arb_found) winner <= arb_idx;
                CLEAR: begin
                    count <= '0;
                    abort <= 1'b0;
                end
                DRAW: begin
                    count <= count + 1'b1;
                    if (!win_done && count == MAX_M1) abort <= 1'b1;
                end
                FINISH: last_grant <= winner;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        eng_enable  = '0;
        eng_reset_n = '1;
        ack         = '0;
        timeout     = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE:   if (arb_found) state_nxt = CLEAR;
            CLEAR: begin
                eng_reset_n = ~win_onehot;
                state_nxt   = DRAW;
            end
            DRAW: begin
                eng_enable = win_onehot;
                if (win_done || count == MAX_M1) state_nxt = FINISH;
            end
            FINISH: begin
                if (abort) timeout = 1'b1;
                else       ack     = win_onehot;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Engines are held in reset for as long as the scheduler itself is.
        if (reset_all) eng_reset_n = '0;
    end

    // Coordinate stage; the ROM's own 1-cycle read latency lines colour up with it.
    always_ff @(posedge clock_all or posedge reset_all) begin
        if (reset_all) begin
            vga_x     <= '0;
            vga_y     <= '0;
            stage_vld <= 1'b0;
        end else begin
            vga_x     <= x_arr[winner];
            vga_y     <= y_arr[winner];
            stage_vld <= (state == DRAW);
        end
    end

    // winner is stable whenever stage_vld is high, so the colour mux needs no extra stage.
    assign vga_colour = stage_vld ? col_arr[winner] : 3'b000;

`ifdef SPRITE_TRANSPARENCY_EN
    assign vga_plot = stage_vld && (vga_colour != TRANS_COLOUR);
`else
    assign vga_plot = stage_vld;
`endif

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
module tb_sprite_draw_scheduler;

    logic        clock_all = 1'b0;
    logic        reset_all = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [3:0]  eng_done;
    logic [35:0] eng_x;
    logic [31:0] eng_y;
    logic [11:0] eng_colour;

    logic [3:0] eng_enable, eng_reset_n, ack;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, timeout;

    logic [3:0] w_eng_enable, w_eng_reset_n, w_ack;
    logic [8:0] w_vga_x;
    logic [7:0] w_vga_y;
    logic [2:0] w_vga_colour;
    logic       w_vga_plot, w_busy, w_timeout;

    logic       use_wd = 1'b0;
    logic [3:0] o_en, o_rstn, o_ack;
    logic [8:0] o_x;
    logic [7:0] o_y;
    logic [2:0] o_col;
    logic       o_plot, o_busy, o_timeout;

    int n_asrt = 0;
    int n_fail = 0;

    logic [15:0] cnt   [4];
    int          len   [4];
    logic [2:0]  tab   [4];
    logic [2:0]  col_q [4];
    logic        exp_plot [4];

    always #5 clock_all = ~clock_all;

    sprite_draw_scheduler #(.NUM_REQ(4)) dut (
        .clock_all(clock_all), .reset_all(reset_all), .req(req), .eng_done(eng_done),
        .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
        .eng_enable(eng_enable), .eng_reset_n(eng_reset_n),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .ack(ack), .timeout(timeout)
    );

    sprite_draw_scheduler #(.NUM_REQ(4), .MAX_CYCLES(16)) dut_wd (
        .clock_all(clock_all), .reset_all(reset_all), .req(req), .eng_done(eng_done),
        .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
        .eng_enable(w_eng_enable), .eng_reset_n(w_eng_reset_n),
        .vga_x(w_vga_x), .vga_y(w_vga_y), .vga_colour(w_vga_colour), .vga_plot(w_vga_plot),
        .busy(w_busy), .ack(w_ack), .timeout(w_timeout)
    );

    assign o_en      = use_wd ? w_eng_enable  : eng_enable;
    assign o_rstn    = use_wd ? w_eng_reset_n : eng_reset_n;
    assign o_ack     = use_wd ? w_ack         : ack;
    assign o_x       = use_wd ? w_vga_x       : vga_x;
    assign o_y       = use_wd ? w_vga_y       : vga_y;
    assign o_col     = use_wd ? w_vga_colour  : vga_colour;
    assign o_plot    = use_wd ? w_vga_plot    : vga_plot;
    assign o_busy    = use_wd ? w_busy        : busy;
    assign o_timeout = use_wd ? w_timeout     : timeout;

    // Engine model: pixel counter, x = 40*i + cnt, y = 10*i + 1, registered colour ROM.
    always @(posedge clock_all) begin
        for (int i = 0; i < 4; i++) begin
            if (!o_rstn[i])     cnt[i] <= 16'd0;
            else if (o_en[i])   cnt[i] <= cnt[i] + 16'd1;
            col_q[i] <= tab[cnt[i][1:0]];
        end
    end

    always_comb begin
        eng_x = '0;
        eng_y = '0;
        eng_colour = '0;
        eng_done = '0;
        for (int i = 0; i < 4; i++) begin
            eng_x[9*i +: 9]      = 9'(40*i) + cnt[i][8:0];
            eng_y[8*i +: 8]      = 8'(10*i + 1);
            eng_colour[3*i +: 3] = col_q[i];
            eng_done[i]          = (cnt[i] == 16'(len[i] - 1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit check);
        req = 4'b0;
        reset_all = 1'b1;
        repeat (2) @(negedge clock_all);
        if (check) begin
            chk("rst eng_enable", 32'(eng_enable), 32'h0);
            chk("rst eng_reset_n", 32'(eng_reset_n), 32'h0);
            chk("rst vga_plot", 32'(vga_plot), 32'h0);
            chk("rst vga_x", 32'(vga_x), 32'h0);
            chk("rst vga_colour", 32'(vga_colour), 32'h0);
            chk("rst busy", 32'(busy), 32'h0);
            chk("rst ack", 32'(ack), 32'h0);
            chk("rst timeout", 32'(timeout), 32'h0);
        end
        reset_all = 1'b0;
        @(negedge clock_all);
        if (check) begin
            chk("post-rst eng_reset_n", 32'(eng_reset_n), 32'hF);
            chk("post-rst busy", 32'(busy), 32'h0);
        end
    endtask

    // Follows one grant from request to ack/timeout, checking grant, every pixel and the end.
    task automatic run_draw(input string tag, input int e, input int npix,
                            input bit expect_to, input bit drop);
        int plots;
        bit seen_en;
        bit fin;
        plots = 0;
        seen_en = 1'b0;
        fin = 1'b0;
        for (int cyc = 0; cyc < npix + 12 && !fin; cyc++) begin
            @(negedge clock_all);
            if (!seen_en && o_en != 4'b0) begin
                seen_en = 1'b1;
                chk({tag, " grant"}, 32'(o_en), 32'(1) << e);
                if (drop) req = 4'b0;
            end
            if (o_plot) begin
                chk({tag, " x"}, 32'(o_x), 32'(40*e + plots));
                chk({tag, " y"}, 32'(o_y), 32'(10*e + 1));
                chk({tag, " colour"}, 32'(o_col), 32'(tab[plots % 4]));
                plots++;
            end
            if (o_ack != 4'b0 || o_timeout) begin
                fin = 1'b1;
                chk({tag, " ack"}, 32'(o_ack), expect_to ? 32'h0 : (32'(1) << e));
                chk({tag, " timeout"}, 32'(o_timeout), 32'(expect_to));
                chk({tag, " plot count"}, 32'(plots), 32'(npix));
            end
        end
        if (!fin) chk({tag, " end of draw within budget"}, 32'h0, 32'h1);
    endtask

    task automatic gap3(input string tag);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock_all);
            chk({tag, " gap no plot"}, 32'(o_plot), 32'h0);
        end
    endtask

    initial begin
        int order2 [4];
        int order3 [5];
        bit ack2_seen;

        tab = '{3'd1, 3'd2, 3'd3, 3'd4};
        len = '{4, 4, 4, 4};
`ifdef SPRITE_TRANSPARENCY_EN
        exp_plot = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_plot = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        // 1: single engine, 20-pixel sprite
        do_reset(1'b1);
        len[0] = 20;
        req = 4'b0001;
        run_draw("t1", 0, 20, 1'b0, 1'b1);
        @(negedge clock_all);
        chk("t1 busy falls", 32'(busy), 32'h0);
        chk("t1 ack single pulse", 32'(ack), 32'h0);
        chk("t1 no plot in idle", 32'(vga_plot), 32'h0);

        // 2: req 1010 held -> 1,3,1,3 with 3 non-plot cycles after each ack
        do_reset(1'b0);
        len[1] = 5;
        len[3] = 7;
        order2 = '{1, 3, 1, 3};
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            run_draw("t2", order2[k], len[order2[k]], 1'b0, k == 3);
            gap3("t2");
        end
        chk("t2 idle at end", 32'(busy), 32'h0);

        // 3: all requesting -> 0,1,2,3,0
        do_reset(1'b0);
        len = '{3, 3, 3, 3};
        order3 = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_draw("t3", order3[k], 3, 1'b0, k == 4);
            gap3("t3");
        end

        // 4: reset mid-draw of engine 2
        do_reset(1'b0);
        len[2] = 50;
        req = 4'b0100;
        repeat (8) @(negedge clock_all);
        chk("t4 drawing", 32'(eng_enable), 32'h4);
        chk("t4 plotting", 32'(vga_plot), 32'h1);
        req = 4'b0;
        reset_all = 1'b1;
        #1;
        chk("t4 plot forced", 32'(vga_plot), 32'h0);
        chk("t4 x forced", 32'(vga_x), 32'h0);
        chk("t4 y forced", 32'(vga_y), 32'h0);
        chk("t4 colour forced", 32'(vga_colour), 32'h0);
        chk("t4 enable forced", 32'(eng_enable), 32'h0);
        chk("t4 reset_n forced", 32'(eng_reset_n), 32'h0);
        chk("t4 busy forced", 32'(busy), 32'h0);
        @(negedge clock_all);
        reset_all = 1'b0;
        ack2_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock_all);
            if (ack[2] || busy) ack2_seen = 1'b1;
        end
        chk("t4 no ack, idle after reset", 32'(ack2_seen), 32'h0);

        // 5: watchdog (MAX_CYCLES=16), engine 0 never done
        use_wd = 1'b1;
        do_reset(1'b0);
        len[0] = 1000;
        req = 4'b0001;
        run_draw("t5", 0, 16, 1'b1, 1'b1);
        @(negedge clock_all);
        chk("t5 timeout one cycle", 32'(w_timeout), 32'h0);
        chk("t5 idle after abort", 32'(w_busy), 32'h0);
        len[1] = 3;
        req = 4'b0011;
        run_draw("t5 last_grant advanced", 1, 3, 1'b0, 1'b1);
        use_wd = 1'b0;

        // 6: colour stream 0,5,0,7 with exact 1-cycle alignment
        do_reset(1'b0);
        tab = '{3'd0, 3'd5, 3'd0, 3'd7};
        len[0] = 4;
        req = 4'b0001;
        @(negedge clock_all);
        chk("t6 clear no plot", 32'(vga_plot), 32'h0);
        chk("t6 clear reset_n", 32'(eng_reset_n), 32'hE);
        @(negedge clock_all);
        chk("t6 draw0 no plot", 32'(vga_plot), 32'h0);
        chk("t6 draw0 enable", 32'(eng_enable), 32'h1);
        req = 4'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock_all);
            chk("t6 plot", 32'(vga_plot), 32'(exp_plot[k]));
            chk("t6 colour", 32'(vga_colour), 32'(tab[k]));
            chk("t6 x", 32'(vga_x), 32'(k));
        end
        chk("t6 ack in finish", 32'(ack), 32'h1);
        @(negedge clock_all);
        chk("t6 idle no plot", 32'(vga_plot), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
